// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the reduced RV32I datapath (addi, lw, bne).
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB with timed memory handshakes.

module multicycle_ctrl_chk (
  input logic       clk,
  input logic       rst,
  input logic       imem_req,
  input logic       dmem_req,
  input logic       RegWrite,
  input logic       PCWrite,
  input logic       PCsrc,
  input logic       halted,
  input logic       trap,
  input logic [1:0] trap_cause
);

  // Memory ports are never requested together; parked states drive nothing.
  a_one_req: assert property (@(posedge clk) disable iff (rst) !(imem_req && dmem_req));
  a_parked_quiet: assert property (@(posedge clk) disable iff (rst)
    (halted || trap) |-> !(RegWrite || PCWrite || imem_req || dmem_req));
  a_halt_trap_excl: assert property (@(posedge clk) disable iff (rst) !(halted && trap));
  a_cause_valid: assert property (@(posedge clk) disable iff (rst) trap == (trap_cause != 2'b00));
  a_wb_seq_pc: assert property (@(posedge clk) disable iff (rst) RegWrite |-> (PCWrite && !PCsrc));

endmodule

module multicycle_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [DATA_WIDTH-1:0] instr_in,
  input  logic                  imem_ready,
  input  logic                  dmem_ready,
  input  logic                  EQ,
  output logic [DATA_WIDTH-1:0] ir,
  output logic                  imem_req,
  output logic                  dmem_req,
  output logic                  PCWrite,
  output logic                  PCsrc,
  output logic                  RegWrite,
  output logic                  ALUsrc,
  output logic [2:0]            ALUctrl,
  output logic [1:0]            ImmSrc,
  output logic                  ResultSrc,
  output logic [CNT_WIDTH-1:0]  instret,
  output logic                  halted,
  output logic                  trap,
  output logic [1:0]            trap_cause
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MEM    = 4'd4,
    S_WB     = 4'd5,
    S_BRANCH = 4'd6,
    S_HALT   = 4'd7,
    S_TRAP   = 4'd8
  } state_t;

  localparam logic [7:0] WAIT_LAST    = 8'(MEM_TIMEOUT - 1);
  localparam logic [2:0] ALU_ADD      = 3'b000;
  localparam logic [2:0] ALU_SUB      = 3'b001;
  localparam logic [1:0] IMM_I        = 2'b00;
  localparam logic [1:0] IMM_B        = 2'b01;
  localparam logic [1:0] CAUSE_IMEM   = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
  localparam logic [1:0] CAUSE_DMEM   = 2'b11;

  state_t      state;
  state_t      next_state;
  logic [7:0]  wait_cnt;
  logic [1:0]  cause_next;
  logic        is_addi;
  logic        is_lw;
  logic        is_bne;
  logic        b_imm_zero;
  logic        wait_timeout;
  logic        branch_halt;

  // Instruction classification from the latched instruction word.
  always_comb begin
    is_addi    = (ir[6:0] == 7'b0010011) && (ir[14:12] == 3'b000);
    is_lw      = (ir[6:0] == 7'b0000011) && (ir[14:12] == 3'b010);
    is_bne     = (ir[6:0] == 7'b1100011) && (ir[14:12] == 3'b001);
    b_imm_zero = ({ir[31], ir[7], ir[30:25], ir[11:8]} == 12'd0);
    wait_timeout = (wait_cnt == WAIT_LAST);
    // A taken branch onto itself is the halt idiom; PC is left alone.
    branch_halt = !EQ && b_imm_zero;
  end

  // State, instruction, wait counter, retire counter and trap cause.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ir         <= {DATA_WIDTH{1'b0}};
      wait_cnt   <= 8'd0;
      instret    <= {CNT_WIDTH{1'b0}};
      trap_cause <= 2'b00;
    end else begin
      state <= next_state;
      if (state == S_FETCH && imem_ready) begin
        ir <= instr_in;
      end
      if ((state == S_FETCH && !imem_ready) || (state == S_MEM && !dmem_ready)) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= 8'd0;
      end
      if (state == S_WB || state == S_BRANCH) begin
        instret <= instret + CNT_WIDTH'(1);
      end
      if (state != S_TRAP && next_state == S_TRAP) begin
        trap_cause <= cause_next;
      end
    end
  end

  // Next-state selection.
  always_comb begin
    next_state = state;
    cause_next = 2'b00;
    case (state)
      S_IDLE: begin
        if (run) next_state = S_FETCH;
        else     next_state = S_IDLE;
      end
      S_FETCH: begin
        if (imem_ready) begin
          next_state = S_DECODE;
        end else if (wait_timeout) begin
          next_state = S_TRAP;
          cause_next = CAUSE_IMEM;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        if (is_addi || is_lw) begin
          next_state = S_EXEC;
        end else if (is_bne) begin
          next_state = S_BRANCH;
        end else begin
          next_state = S_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        if (is_lw) next_state = S_MEM;
        else       next_state = S_WB;
      end
      S_MEM: begin
        if (dmem_ready) begin
          next_state = S_WB;
        end else if (wait_timeout) begin
          next_state = S_TRAP;
          cause_next = CAUSE_DMEM;
        end else begin
          next_state = S_MEM;
        end
      end
      S_WB: begin
        if (run) next_state = S_FETCH;
        else     next_state = S_IDLE;
      end
      S_BRANCH: begin
        if (branch_halt) next_state = S_HALT;
        else if (run)    next_state = S_FETCH;
        else             next_state = S_IDLE;
      end
      S_HALT:  next_state = S_HALT;
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_IDLE;
    endcase
  end

  // Moore strobe decode; WB keeps the ALU operands so the addi result stays valid.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    PCWrite   = 1'b0;
    PCsrc     = 1'b0;
    RegWrite  = 1'b0;
    ALUsrc    = 1'b0;
    ALUctrl   = ALU_ADD;
    ImmSrc    = IMM_I;
    ResultSrc = 1'b0;
    halted    = (state == S_HALT);
    trap      = (state == S_TRAP);
    case (state)
      S_FETCH: imem_req = 1'b1;
      S_EXEC: begin
        ALUsrc  = 1'b1;
        ALUctrl = ALU_ADD;
        ImmSrc  = IMM_I;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        ALUsrc   = 1'b1;
        ALUctrl  = ALU_ADD;
      end
      S_WB: begin
        RegWrite  = 1'b1;
        ResultSrc = is_lw;
        PCWrite   = 1'b1;
        PCsrc     = 1'b0;
        ALUsrc    = 1'b1;
      end
      S_BRANCH: begin
        ALUsrc  = 1'b0;
        ALUctrl = ALU_SUB;
        ImmSrc  = IMM_B;
        PCsrc   = ~EQ;
        PCWrite = ~branch_halt;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  multicycle_ctrl_chk u_chk (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .RegWrite   (RegWrite),
    .PCWrite    (PCWrite),
    .PCsrc      (PCsrc),
    .halted     (halted),
    .trap       (trap),
    .trap_cause (trap_cause)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a stimulus process pushes expected retire/halt/trap
// records computed from instruction semantics; a negedge monitor pops and compares them.

module tb_multicycle_ctrl;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int TO = 64;

  localparam int K_ADDI = 0;
  localparam int K_LW   = 1;
  localparam int K_BNE  = 2;
  localparam int K_ILL  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [DW-1:0] instr_in;
  logic          imem_ready;
  logic          dmem_ready;
  logic          EQ;
  logic [DW-1:0] ir;
  logic          imem_req, dmem_req, PCWrite, PCsrc, RegWrite, ALUsrc, ResultSrc;
  logic [2:0]    ALUctrl;
  logic [1:0]    ImmSrc;
  logic [CW-1:0] instret;
  logic          halted, trap;
  logic [1:0]    trap_cause;

  multicycle_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .run(run), .instr_in(instr_in),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .EQ(EQ),
    .ir(ir), .imem_req(imem_req), .dmem_req(dmem_req), .PCWrite(PCWrite),
    .PCsrc(PCsrc), .RegWrite(RegWrite), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl),
    .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .instret(instret),
    .halted(halted), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ir;
    logic [9:0]  strb;   // {RegWrite,ResultSrc,PCWrite,PCsrc,ALUsrc,ALUctrl,ImmSrc}
    logic [31:0] instret;
    logic [15:0] lat;    // cycles from first FETCH cycle through the event cycle
    logic [15:0] dcyc;   // dmem_req cycles for this instruction
    logic [3:0]  flags;  // {halted,trap,trap_cause}
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_ret = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  function automatic int classify(logic [31:0] x);
    if (x[6:0] == 7'b0010011 && x[14:12] == 3'b000) return K_ADDI;
    if (x[6:0] == 7'b0000011 && x[14:12] == 3'b010) return K_LW;
    if (x[6:0] == 7'b1100011 && x[14:12] == 3'b001) return K_BNE;
    return K_ILL;
  endfunction

  function automatic bit bimm_zero(logic [31:0] x);
    logic [12:0] imm;
    imm = {x[31], x[7], x[30:25], x[11:8], 1'b0};
    return imm == 13'd0;
  endfunction

  function automatic exp_t mk(logic [31:0] x, logic [9:0] s, int lat, int dc, logic [3:0] f);
    exp_t e;
    e.ir = x; e.strb = s; e.instret = 32'(n_ret % 16);
    e.lat = 16'(lat); e.dcyc = 16'(dc); e.flags = f;
    return e;
  endfunction

  // Expected observable events of one instruction, from its semantics and the chosen waits.
  function automatic void push_exp(logic [31:0] x, int wi, int wd, bit eq);
    bit halt;
    case (classify(x))
      K_ADDI: begin sb.push_back(mk(x, 10'b1_0_1_0_1_000_00, 4 + wi, 0, 4'b0000)); n_ret++; end
      K_LW:   begin sb.push_back(mk(x, 10'b1_1_1_0_1_000_00, 5 + wi + wd, wd + 1, 4'b0000)); n_ret++; end
      K_BNE: begin
        halt = !eq && bimm_zero(x);
        sb.push_back(mk(x, {3'b000, !eq, 1'b0, 3'b001, 2'b01} | {2'b00, !halt, 7'd0},
                        3 + wi, 0, 4'b0000));
        n_ret++;
        if (halt) sb.push_back(mk(x, 10'd0, 4 + wi, 0, 4'b1000));
      end
      default: sb.push_back(mk(x, 10'd0, 3 + wi, 0, 4'b0110));
    endcase
  endfunction

  task automatic serve_imem(logic [31:0] x, int wi, bit eq);
    int t = 0;
    @(negedge clk);
    while (!imem_req && t < 300) begin @(negedge clk); t++; end
    if (!imem_req) begin bound_fail("imem_req_wait"); return; end
    repeat (wi) @(negedge clk);
    #1;
    instr_in = x; EQ = eq; imem_ready = 1'b1;
    @(posedge clk); #1;
    imem_ready = 1'b0; instr_in = $urandom;
  endtask

  task automatic serve_dmem(int wd);
    int t = 0;
    @(negedge clk);
    while (!dmem_req && t < 300) begin @(negedge clk); t++; end
    if (!dmem_req) begin bound_fail("dmem_req_wait"); return; end
    repeat (wd) @(negedge clk);
    #1 dmem_ready = 1'b1;
    @(posedge clk); #1 dmem_ready = 1'b0;
  endtask

  task automatic do_instr(logic [31:0] x, int wi, int wd, bit eq, bit drop);
    push_exp(x, wi, wd, eq);
    serve_imem(x, wi, eq);
    if (drop) begin @(posedge clk); #1 run = 1'b0; end
    if (classify(x) == K_LW) serve_dmem(wd);
  endtask

  function automatic logic [31:0] rand_instr(int k);
    logic [31:0] x;
    x = $urandom;
    case (k)
      K_ADDI:  begin x[14:12] = 3'b000; x[6:0] = 7'b0010011; end
      K_LW:    begin x[14:12] = 3'b010; x[6:0] = 7'b0000011; end
      default: begin x[14:12] = 3'b001; x[6:0] = 7'b1100011; end
    endcase
    return x;
  endfunction

  task automatic wait_flag(bit want_trap, int bound);
    int t = 0;
    @(negedge clk);
    while (!(want_trap ? trap : halted) && t < bound) begin @(negedge clk); t++; end
    if (!(want_trap ? trap : halted)) bound_fail(want_trap ? "trap_wait" : "halt_wait");
  endtask

  task automatic check_reset(string tag);
    chk({tag, "_ir"}, ir, 0);
    chk({tag, "_instret"}, instret, 0);
    chk({tag, "_strobes"}, {imem_req, dmem_req, RegWrite, ResultSrc, PCWrite, PCsrc, ALUsrc, ALUctrl, ImmSrc}, 0);
    chk({tag, "_flags"}, {halted, trap, trap_cause}, 0);
  endtask

  task automatic reset_dut(string tag);
    @(posedge clk); #1 rst = 1'b1;
    imem_ready = 1'b0; dmem_ready = 1'b0; instr_in = 32'd0;
    @(posedge clk); #1;
    check_reset(tag);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    sb.delete();
    n_ret = 0;
    rst = 1'b0;
  endtask

  // Monitor: pops an expectation whenever the DUT shows a retire, halt or trap event.
  initial begin : monitor
    int cyc, start, dcnt;
    bit pim, ph, pt, ev;
    exp_t e;
    cyc = 0; start = 0; dcnt = 0; pim = 1'b0; ph = 1'b0; pt = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0; start = 0; dcnt = 0; pim = 1'b0; ph = 1'b0; pt = 1'b0;
      end else begin
        cyc++;
        if (imem_req && !pim) begin start = cyc; dcnt = 0; end
        if (dmem_req) dcnt++;
        ev = RegWrite || PCWrite || (ALUctrl == 3'b001) || (halted && !ph) || (trap && !pt);
        if (ev) begin
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_event: RegWrite=%0b PCWrite=%0b ALUctrl=%0b halted=%0b trap=%0b expected none",
                     RegWrite, PCWrite, ALUctrl, halted, trap);
          end else begin
            e = sb.pop_front();
            chk("ev_ir", ir, e.ir);
            chk("ev_strobes", {RegWrite, ResultSrc, PCWrite, PCsrc, ALUsrc, ALUctrl, ImmSrc}, e.strb);
            chk("ev_instret", instret, e.instret);
            chk("ev_latency", cyc - start + 1, e.lat);
            chk("ev_dmem_cycles", dcnt, e.dcyc);
            chk("ev_flags", {halted, trap, trap_cause}, e.flags);
          end
        end
        pim = imem_req; ph = halted; pt = trap;
      end
    end
  end

  initial begin : stimulus
    int k, wi, wd, idle_fetch;
    bit eq;
    logic [31:0] x;
    rst = 1'b1; run = 1'b0; instr_in = 32'd0; imem_ready = 1'b0; dmem_ready = 1'b0; EQ = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset("reset");
    rst = 1'b0; run = 1'b1;

    // Directed: addi, lw with 3 dmem waits, bne not taken, then a random mix and a self-branch halt.
    do_instr(32'h00500513, 0, 0, 1'b0, 1'b0);
    do_instr(32'h00002583, 0, 3, 1'b0, 1'b0);
    do_instr(32'h00051063, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 2);
      x = rand_instr(k);
      wi = $urandom_range(0, 4);
      wd = $urandom_range(0, 4);
      eq = 1'($urandom_range(0, 1));
      if (k == K_BNE && !eq && bimm_zero(x)) x[8] = 1'b1;
      do_instr(x, wi, wd, eq, 1'b0);
    end
    do_instr(32'h00051063, $urandom_range(0, 3), 0, 1'b0, 1'b0);
    wait_flag(1'b0, 100);
    repeat (5) @(negedge clk);
    chk("halt_sticky", {halted, trap, imem_req}, 3'b100);
    chk("halt_instret_wrap", instret, 32'(n_ret % 16));

    // run dropped during EXEC: the addi retires, then the core parks without fetching.
    reset_dut("rst_after_halt");
    run = 1'b1;
    do_instr(rand_instr(K_ADDI), 1, 0, 1'b0, 1'b0);
    do_instr(rand_instr(K_ADDI), 0, 0, 1'b0, 1'b1);
    idle_fetch = 0;
    repeat (8) begin @(negedge clk); if (imem_req) idle_fetch++; end
    chk("idle_no_fetch", idle_fetch, 0);
    chk("idle_instret", instret, 2);
    #1 run = 1'b1;
    do_instr(rand_instr(K_LW), 2, 1, 1'b0, 1'b0);
    do_instr(32'h00000000, 2, 0, 1'b0, 1'b0);
    wait_flag(1'b1, 100);
    repeat (3) @(negedge clk);
    chk("illegal_trap_sticky", {halted, trap, trap_cause}, 4'b0110);

    // Instruction memory never answers: trap after exactly MEM_TIMEOUT fetch cycles.
    reset_dut("rst_after_trap");
    sb.push_back(mk(32'd0, 10'd0, TO + 1, 0, 4'b0101));
    wait_flag(1'b1, 200);
    repeat (3) @(negedge clk);
    chk("imem_timeout_sticky", {trap, trap_cause, imem_req}, 4'b1010);

    // Reset in the middle of a data-memory wait.
    reset_dut("rst_after_timeout");
    serve_imem(32'h00002583, 0, 1'b0);
    @(negedge clk);
    while (!dmem_req && idle_fetch < 300) begin @(negedge clk); idle_fetch++; end
    chk("mem_wait_reached", dmem_req, 1'b1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check_reset("rst_mid_mem");
    rst = 1'b0;

    // Near-miss encoding (addi opcode, wrong funct3) is illegal.
    do_instr(32'h00001013, 0, 0, 1'b0, 1'b0);
    wait_flag(1'b1, 100);
    @(negedge clk);
    chk("near_miss_cause", trap_cause, 2'b10);
    chk("final_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
